// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the NPC general-purpose register file.
//   REG_DEPTH : entry count for the default 5-bit index
//   ZERO_IDX  : index of the hardwired-zero register
//   port_lsb  : LSB position of packed port k in a bus of width-bit fields
package regfile_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int REG_DEPTH      = 2 ** DEF_ADDR_WIDTH;
    localparam int ZERO_IDX       = 0;

    function automatic int port_lsb(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port of regfile_sb: array mux, write-to-read
// bypass and busy indication for the addressed register.
//   raddr      : register index for this port
//   wen/waddr/wdata : writeback in flight this cycle (bypass source)
//   rf         : storage array
//   busy       : scoreboard bits
//   rdata      : read data (0 for x0 when ZERO_REG)
//   rbusy      : register still waiting for a writeback
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int ZERO_REG   = 1
) (
    input  logic [ADDR_WIDTH-1:0]    raddr,
    input  logic                     wen,
    input  logic [ADDR_WIDTH-1:0]    waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [DATA_WIDTH-1:0]    rf [2**ADDR_WIDTH],
    input  logic [2**ADDR_WIDTH-1:0] busy,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     rbusy
);

    logic is_zero;
    logic wr_hit;

    assign is_zero = (ZERO_REG != 0) && (raddr == ADDR_WIDTH'(ZERO_IDX));
    assign wr_hit  = wen && (waddr == raddr);

    always_comb begin
        rdata = rf[raddr];
        rbusy = busy[raddr];
        if (is_zero) begin
            rdata = '0;
            rbusy = 1'b0;
        end else if (wr_hit) begin
            // The bypass already delivers the data, so the pending
            // write no longer blocks the reader.
            rdata = wdata;
            rbusy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// General-purpose register file with busy scoreboard for the NPC core.
//   clk, rst_n          : clock, async active-low reset (clears everything)
//   wen, waddr, wdata   : writeback port, also clears the busy bit
//   raddr / rdata       : NUM_READ packed read ports, combinational
//   rbusy               : per read port, register has a pending write
//   issue_en, issue_rd  : decode marks a destination busy
//   waw_hit             : registered, issue hit an already-busy register
//   busy_cnt            : registered count of busy registers
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wen,
    input  logic [ADDR_WIDTH-1:0]          waddr,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
    output logic [NUM_READ-1:0]            rbusy,
    input  logic                           issue_en,
    input  logic [ADDR_WIDTH-1:0]          issue_rd,
    output logic                           waw_hit,
    output logic [ADDR_WIDTH:0]            busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rf [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_nxt;

    logic wr_ok;
    logic issue_ok;
    logic cnt_inc;
    logic cnt_dec;
    logic waw_nxt;

    assign wr_ok    = wen && !((ZERO_REG != 0) && (waddr == ADDR_WIDTH'(ZERO_IDX)));
    assign issue_ok = issue_en && !((ZERO_REG != 0) && (issue_rd == ADDR_WIDTH'(ZERO_IDX)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
        end else if (wr_ok) begin
            rf[waddr] <= wdata;
        end
    end

    // Issue is applied after the writeback clear so a new producer wins.
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < DEPTH; i++) begin
            if (wen && (waddr == ADDR_WIDTH'(i))) busy_nxt[i] = 1'b0;
            if (issue_ok && (issue_rd == ADDR_WIDTH'(i))) busy_nxt[i] = 1'b1;
        end
        if (ZERO_REG != 0) busy_nxt[ZERO_IDX] = 1'b0;
    end

    // Counter moves only on real bit transitions; an issue and writeback
    // to the same busy index leave the bit (and the count) unchanged.
    assign cnt_inc = issue_ok && !busy[issue_rd];
    assign cnt_dec = wen && busy[waddr] && !(issue_ok && (issue_rd == waddr));
    assign waw_nxt = issue_ok && busy[issue_rd] && !(wen && (waddr == issue_rd));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
            waw_hit  <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= busy_cnt + {{ADDR_WIDTH{1'b0}}, cnt_inc}
                                 - {{ADDR_WIDTH{1'b0}}, cnt_dec};
            waw_hit  <= waw_nxt;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        regfile_rd_port #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .DATA_WIDTH(DATA_WIDTH),
            .ZERO_REG  (ZERO_REG)
        ) u_rd (
            .raddr(raddr[port_lsb(k, ADDR_WIDTH) +: ADDR_WIDTH]),
            .wen  (wen),
            .waddr(waddr),
            .wdata(wdata),
            .rf   (rf),
            .busy (busy),
            .rdata(rdata[port_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
            .rbusy(rbusy[k])
        );
    end

endmodule
